core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
- Multi-cycle FSM that steps the RV32I core through fetch, decode, execute, memory and writeback.
- Consumes the per-opcode control signals from the decode stage and drives the phase enables: PC update, IR load, ALU capture, memory request and register-file commit.
- Arbitrates the single shared memory port between instruction fetch and data access, with ack-based wait states and a bounded timeout.

Parameters:
- MEM_TIMEOUT, 16, cycles a memory request may wait for mem_ack before FAULT. Value 0 disables the timeout.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  start/continue execution; sampled in IDLE and at retire
- regfile_wr_en  in  1  decoded: instruction writes rd
- mem_rd_en  in  1  decoded: load
- mem_wr_en  in  1  decoded: store
- is_branch_instruction  in  1  decoded: branch
- branch_taken  in  1  ALU compare result; valid in EXECUTE
- mem_ack  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request; held high until mem_ack
- mem_addr_sel  out  1  0 = PC (fetch), 1 = ALU result (data)
- mem_we  out  1  write strobe; qualified by mem_req
- ir_load  out  1  latch fetched instruction into IR
- alu_en  out  1  capture ALU result register
- mem_data_latch  out  1  latch load data into MDR
- rf_commit  out  1  register-file write enable
- pc_en  out  1  update PC; doubles as instruction-retired pulse
- pc_sel  out  1  0 = PC+4, 1 = branch target
- fault  out  1  sticky memory-timeout fault
- state  out  3  current state encoding, for debug

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, FAULT=6. Code 7 is unreachable and recovers to IDLE.
- State is registered. All outputs are combinational from the current state and inputs (Moore, plus ack-qualified Mealy strobes).
- Reset (async, rst_n=0): state=IDLE, wait counter=0. All outputs 0, including fault.
- IDLE: all outputs 0. If run=1, go to FETCH.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0.
  - If mem_ack=1: ir_load=1 and go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE: one cycle with no strobes, so the decode signals can settle. Then go to EXECUTE.
- EXECUTE: alu_en=1. Next state by priority:
  - (mem_rd_en | mem_wr_en) -> MEM.
  - regfile_wr_en -> WRITEBACK.
  - Otherwise retire this cycle: pc_en=1, pc_sel = is_branch_instruction & branch_taken.
- MEM: mem_req=1, mem_addr_sel=1, mem_we = mem_wr_en & ~mem_rd_en. mem_rd_en wins if both are set.
  - On mem_ack with a load: mem_data_latch=1, go to WRITEBACK.
  - On mem_ack with a store: retire (pc_en=1, pc_sel=0).
- WRITEBACK: rf_commit=1, pc_en=1, pc_sel=0.
- Retire (any retire cycle): next state is FETCH if run=1, else IDLE. Deasserting run never aborts an in-flight instruction.
- Opcode with no decoded controls: flows FETCH -> DECODE -> EXECUTE and retires as a no-op, with pc_sel=0 unless is_branch_instruction is set.
- Wait counter:
  - Cleared on entry to FETCH or MEM and on every ack.
  - Counts cycles in FETCH/MEM with mem_ack=0.
  - When it reaches MEM_TIMEOUT with no ack, go to FAULT on the next edge.
  - An ack in the same cycle as the timeout wins: the ack is honoured and there is no fault.
  - Counter width is clog2(MEM_TIMEOUT+1), minimum 1 bit.
- FAULT: fault=1, all other outputs 0, mem_req dropped. The only exit is reset.
- mem_ack outside FETCH/MEM is ignored.
- Reset asserted mid-request drops mem_req asynchronously.
- Latency with zero-wait memory (cycles from the FETCH cycle through the retire cycle, inclusive):
  - Branch / no-op: 3.
  - ALU / ALUI: 4.
  - Store: 4.
  - Load: 5.
  - Each wait state adds 1.

Optional Feature:
- Macro: CORE_SEQUENCER_PERF_COUNTERS_EN.
- When defined, two extra output ports are added:
  - perf_cycles [31:0]: increments every cycle state is not IDLE or FAULT.
  - perf_instret [31:0]: increments on every pc_en.
  - Both reset to 0, wrap modulo 2^32 and freeze in FAULT.
- When undefined, the ports and logic are absent and the block is otherwise identical.

Test Plan:
- Reset, run=1, ALU op (regfile_wr_en=1), mem_ack=1 in FETCH -> states 1,2,3,5,1. ir_load at cycle 0, alu_en at cycle 2, rf_commit+pc_en at cycle 3.
- Load with 2 wait cycles in MEM -> mem_req held 3 cycles with mem_addr_sel=1, mem_we=0. mem_data_latch on the ack cycle, then WRITEBACK with rf_commit=1, pc_en=1.
- Taken branch (is_branch_instruction=1, branch_taken=1) -> pc_en=1, pc_sel=1 in EXECUTE; total 3 cycles; no rf_commit.
- Store with run dropped during MEM -> mem_we=1 until ack, retire with pc_en=1, then state=0 (IDLE), mem_req=0.
- MEM_TIMEOUT=4, mem_ack held 0 in FETCH -> after 4 wait cycles state=6, fault=1 sticky, mem_req=0. rst_n pulse returns to IDLE with fault=0.
- Ack on the exact timeout cycle -> DECODE entered, fault stays 0. With the macro defined, perf_instret=N after N retires and perf_cycles matches the cycle count.

Source files
------------

// File: rtl/core_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module  : core_sequencer_if
//  Purpose : Shared single-port memory handshake between the RV32I
//            sequencer (master) and the memory subsystem (slave).
//  Rev     : 1.0  initial release
// ============================================================================
interface core_sequencer_if;
   logic mem_req;       // request, held until mem_ack
   logic mem_addr_sel;  // 0 = PC (fetch), 1 = ALU result (data)
   logic mem_we;        // write strobe, qualified by mem_req
   logic mem_ack;       // memory completes the current request

   modport master (
      output mem_req,
      output mem_addr_sel,
      output mem_we,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_addr_sel,
      input  mem_we,
      output mem_ack
   );
endinterface
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : core_sequencer
//  Purpose : Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for an
//            RV32I core. Drives the phase enables, arbitrates the shared
//            memory port and faults on a bounded memory-ack timeout.
//  Options : CORE_SEQUENCER_PERF_COUNTERS_EN adds perf_cycles/perf_instret.
//  Rev     : 1.0  initial release
// ============================================================================
module core_sequencer #(
   parameter int MEM_TIMEOUT = 16   // 0 disables the timeout
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   core_sequencer_if.master bus,
   input  wire logic        run,
   input  wire logic        regfile_wr_en,
   input  wire logic        mem_rd_en,
   input  wire logic        mem_wr_en,
   input  wire logic        is_branch_instruction,
   input  wire logic        branch_taken,
   output logic             ir_load,
   output logic             alu_en,
   output logic             mem_data_latch,
   output logic             rf_commit,
   output logic             pc_en,
   output logic             pc_sel,
   output logic             fault,
   output logic [2:0]       state
`ifdef CORE_SEQUENCER_PERF_COUNTERS_EN
   ,
   output logic [31:0]      perf_cycles,
   output logic [31:0]      perf_instret
`endif
);

   localparam logic [2:0] C_IDLE      = 3'd0;
   localparam logic [2:0] C_FETCH     = 3'd1;
   localparam logic [2:0] C_DECODE    = 3'd2;
   localparam logic [2:0] C_EXECUTE   = 3'd3;
   localparam logic [2:0] C_MEM       = 3'd4;
   localparam logic [2:0] C_WRITEBACK = 3'd5;
   localparam logic [2:0] C_FAULT     = 3'd6;

   // Counter must be able to hold the value MEM_TIMEOUT itself
   localparam int               C_CW      = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [C_CW-1:0]  C_TIMEOUT = C_CW'(MEM_TIMEOUT);
   localparam bit               C_TO_EN   = (MEM_TIMEOUT != 0);

   logic [2:0]      r_state;
   logic [2:0]      w_next_state;
   logic [2:0]      w_retire_state;
   logic [C_CW-1:0] r_wait;
   logic            w_mem_phase;
   logic            w_timeout;

   assign state          = r_state;
   assign w_mem_phase    = (r_state == C_FETCH) || (r_state == C_MEM);
   // An ack on the timeout cycle takes priority, so the timeout needs !ack
   assign w_timeout      = C_TO_EN && w_mem_phase && !bus.mem_ack && (r_wait == C_TIMEOUT);
   // Run is only honoured at instruction boundaries
   assign w_retire_state = run ? C_FETCH : C_IDLE;

   // State register and memory wait counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= C_IDLE;
         r_wait  <= '0;
      end else begin
         r_state <= w_next_state;
         // Counting only while staying in a waiting memory phase; any exit,
         // entry or ack leaves the counter cleared
         if (w_mem_phase && !bus.mem_ack && (w_next_state == r_state))
            r_wait <= r_wait + C_CW'(1);
         else
            r_wait <= '0;
      end
   end

   // Next-state selection
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         C_IDLE: begin
            if (run)
               w_next_state = C_FETCH;
         end
         C_FETCH: begin
            if (bus.mem_ack)
               w_next_state = C_DECODE;
            else if (w_timeout)
               w_next_state = C_FAULT;
         end
         C_DECODE: begin
            w_next_state = C_EXECUTE;
         end
         C_EXECUTE: begin
            if (mem_rd_en || mem_wr_en)
               w_next_state = C_MEM;
            else if (regfile_wr_en)
               w_next_state = C_WRITEBACK;
            else
               w_next_state = w_retire_state;
         end
         C_MEM: begin
            if (bus.mem_ack)
               w_next_state = mem_rd_en ? C_WRITEBACK : w_retire_state;
            else if (w_timeout)
               w_next_state = C_FAULT;
         end
         C_WRITEBACK: begin
            w_next_state = w_retire_state;
         end
         C_FAULT: begin
            w_next_state = C_FAULT;
         end
         default: begin
            w_next_state = C_IDLE;
         end
      endcase
   end

   // Phase enables and memory strobes from state (plus ack-qualified strobes)
   always_comb begin
      bus.mem_req      = 1'b0;
      bus.mem_addr_sel = 1'b0;
      bus.mem_we       = 1'b0;
      ir_load          = 1'b0;
      alu_en           = 1'b0;
      mem_data_latch   = 1'b0;
      rf_commit        = 1'b0;
      pc_en            = 1'b0;
      pc_sel           = 1'b0;
      fault            = 1'b0;
      case (r_state)
         C_FETCH: begin
            bus.mem_req = 1'b1;
            ir_load     = bus.mem_ack;
         end
         C_EXECUTE: begin
            alu_en = 1'b1;
            // Neither memory nor register write: the instruction retires here
            if (!(mem_rd_en || mem_wr_en) && !regfile_wr_en) begin
               pc_en  = 1'b1;
               pc_sel = is_branch_instruction & branch_taken;
            end
         end
         C_MEM: begin
            bus.mem_req      = 1'b1;
            bus.mem_addr_sel = 1'b1;
            bus.mem_we       = mem_wr_en & ~mem_rd_en;
            mem_data_latch   = bus.mem_ack & mem_rd_en;
            pc_en            = bus.mem_ack & ~mem_rd_en;
         end
         C_WRITEBACK: begin
            rf_commit = 1'b1;
            pc_en     = 1'b1;
         end
         C_FAULT: begin
            fault = 1'b1;
         end
         default: begin
         end
      endcase
   end

`ifdef CORE_SEQUENCER_PERF_COUNTERS_EN
   logic [31:0] r_perf_cycles;
   logic [31:0] r_perf_instret;

   assign perf_cycles  = r_perf_cycles;
   assign perf_instret = r_perf_instret;

   // Active-cycle and retired-instruction counters; frozen while in FAULT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_cycles  <= '0;
         r_perf_instret <= '0;
      end else begin
         if ((r_state != C_IDLE) && (r_state != C_FAULT))
            r_perf_cycles <= r_perf_cycles + 32'd1;
         if (pc_en)
            r_perf_instret <= r_perf_instret + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_core_sequencer
//  Purpose : Self-checking bench for core_sequencer with a memory responder
//            and an instruction-level reference model.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_core_sequencer;
   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       run, rf, rd, wr, br, tk;
   logic       ir_load, alu_en, mem_data_latch, rf_commit, pc_en, pc_sel, fault;
   logic [2:0] state;
`ifdef CORE_SEQUENCER_PERF_COUNTERS_EN
   logic [31:0] perf_cycles, perf_instret;
`endif

   int total = 0;
   int bad   = 0;

   core_sequencer_if bus();

   core_sequencer #(.MEM_TIMEOUT(TO)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .bus                   (bus),
      .run                   (run),
      .regfile_wr_en         (rf),
      .mem_rd_en             (rd),
      .mem_wr_en             (wr),
      .is_branch_instruction (br),
      .branch_taken          (tk),
      .ir_load               (ir_load),
      .alu_en                (alu_en),
      .mem_data_latch        (mem_data_latch),
      .rf_commit             (rf_commit),
      .pc_en                 (pc_en),
      .pc_sel                (pc_sel),
      .fault                 (fault),
      .state                 (state)
`ifdef CORE_SEQUENCER_PERF_COUNTERS_EN
      ,
      .perf_cycles           (perf_cycles),
      .perf_instret          (perf_instret)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] outs();
      return {bus.mem_req, bus.mem_addr_sel, bus.mem_we, ir_load, alu_en,
              mem_data_latch, rf_commit, pc_en, pc_sel, fault};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      run = 0; rf = 0; rd = 0; wr = 0; br = 0; tk = 0;
      bus.mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // From IDLE, raise run and expect FETCH on the next edge
   task automatic start_run(input string nm);
      run = 1'b1;
      tick();
      total++;
      if (state !== 3'd1) begin
         bad++;
         $display("FAIL %s start: state=%0d required=1", nm, state);
      end
   endtask

   // Runs one instruction starting in FETCH. Memory acks after fw fetch
   // wait states and mw data wait states. run takes run_after once decode
   // is reached. Returns the model's cycle count for the instruction.
   task automatic run_instr(input string nm, input bit i_rd, input bit i_wr,
                            input bit i_rf, input bit i_br, input bit i_tk,
                            input int fw, input int mw, input bit run_after,
                            output int lat);
      int  exp_st[$];
      int  obs_st[$];
      bit  is_mem, is_load, is_store, got, psel, tr_ok;
      int  e_rf, e_mdl, e_dreq, e_we;
      int  n_ir, n_alu, n_rf, n_mdl, n_dreq, n_we, fcnt, dcnt;
      rd = i_rd; wr = i_wr; rf = i_rf; br = i_br; tk = i_tk;
      is_mem   = i_rd | i_wr;
      is_load  = i_rd;
      is_store = i_wr & ~i_rd;
      // Reference: phase sequence derived from the instruction class
      repeat (fw + 1) exp_st.push_back(1);
      exp_st.push_back(2);
      exp_st.push_back(3);
      if (is_mem) repeat (mw + 1) exp_st.push_back(4);
      if (is_load || (!is_mem && i_rf)) exp_st.push_back(5);
      lat    = exp_st.size();
      e_rf   = (is_load || (!is_mem && i_rf)) ? 1 : 0;
      e_mdl  = is_load ? 1 : 0;
      e_dreq = is_mem ? mw + 1 : 0;
      e_we   = is_store ? mw + 1 : 0;
      n_ir = 0; n_alu = 0; n_rf = 0; n_mdl = 0; n_dreq = 0; n_we = 0;
      fcnt = 0; dcnt = 0; got = 0; psel = 0;
      for (int c = 0; c < 40 && !got; c++) begin
         if (bus.mem_req && !bus.mem_addr_sel) begin
            bus.mem_ack = (fcnt == fw); fcnt++;
         end else if (bus.mem_req && bus.mem_addr_sel) begin
            bus.mem_ack = (dcnt == mw); dcnt++;
         end else begin
            bus.mem_ack = 1'b0;
         end
         #1;
         obs_st.push_back(int'(state));
         n_ir  += int'(ir_load);
         n_alu += int'(alu_en);
         n_rf  += int'(rf_commit);
         n_mdl += int'(mem_data_latch);
         n_dreq += int'(bus.mem_req & bus.mem_addr_sel);
         n_we  += int'(bus.mem_req & bus.mem_we);
         if (pc_en) begin
            got  = 1;
            psel = pc_sel;
         end
         if (state != 3'd1) run = run_after;
         @(posedge clk);
         #1;
      end
      bus.mem_ack = 1'b0;
      #1;
      total++;
      if (!got) begin
         bad++;
         $display("FAIL %s retire: no pc_en within 40 cycles", nm);
      end
      tr_ok = (obs_st.size() == exp_st.size());
      if (tr_ok)
         foreach (exp_st[i]) if (obs_st[i] != exp_st[i]) tr_ok = 0;
      total++;
      if (!tr_ok) begin
         bad++;
         $display("FAIL %s trace: got %0d cycles %p, required %0d cycles %p",
                  nm, obs_st.size(), obs_st, exp_st.size(), exp_st);
      end
      total++;
      if (n_ir != 1 || n_alu != 1 || n_rf != e_rf || n_mdl != e_mdl ||
          n_dreq != e_dreq || n_we != e_we) begin
         bad++;
         $display("FAIL %s strobes: ir=%0d alu=%0d rf=%0d mdl=%0d dreq=%0d we=%0d required 1 1 %0d %0d %0d %0d",
                  nm, n_ir, n_alu, n_rf, n_mdl, n_dreq, n_we, e_rf, e_mdl, e_dreq, e_we);
      end
      total++;
      if (psel !== (!is_mem && !i_rf && i_br && i_tk)) begin
         bad++;
         $display("FAIL %s pc_sel: got %0b required %0b", nm, psel,
                  (!is_mem && !i_rf && i_br && i_tk));
      end
      total++;
      if (state !== (run_after ? 3'd1 : 3'd0) || bus.mem_req !== run_after || fault !== 1'b0) begin
         bad++;
         $display("FAIL %s post: state=%0d mem_req=%0b fault=%0b required state=%0d mem_req=%0b fault=0",
                  nm, state, bus.mem_req, fault, run_after ? 1 : 0, run_after);
      end
   endtask

   task automatic test_reset();
      bit ok;
      rst_n = 1'b0;
      run = 0; rf = 0; rd = 0; wr = 0; br = 0; tk = 0;
      bus.mem_ack = 1'b0;
      #3;
      total++;
      if (state !== 3'd0 || outs() !== 10'd0) begin
         bad++;
         $display("FAIL reset: state=%0d outs=%b required state=0 outs=0", state, outs());
      end
      tick();
      rst_n = 1'b1;
      // IDLE with run low ignores a stray ack
      bus.mem_ack = 1'b1;
      ok = 1;
      repeat (3) begin
         tick();
         if (state !== 3'd0 || outs() !== 10'd0) ok = 0;
      end
      bus.mem_ack = 1'b0;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL idle_hold: state=%0d outs=%b required state=0 outs=0", state, outs());
      end
   endtask

   task automatic test_directed();
      int lat;
      do_reset();
      start_run("alu");
      run_instr("alu",        0, 0, 1, 0, 0, 0, 0, 1, lat);
      run_instr("load_wait2", 1, 0, 1, 0, 0, 0, 2, 1, lat);
      run_instr("branch_tk",  0, 0, 0, 1, 1, 0, 0, 1, lat);
      run_instr("branch_nt",  0, 0, 0, 1, 0, 1, 0, 1, lat);
      run_instr("store_drop", 0, 1, 0, 0, 0, 0, 1, 0, lat);
      start_run("ack_at_timeout");
      run_instr("ack_at_timeout", 0, 0, 1, 0, 0, TO, 0, 1, lat);
      run_instr("mem_ack_at_timeout", 0, 1, 0, 0, 0, 0, TO, 0, lat);
   endtask

   task automatic test_fetch_timeout();
      bit ok;
      do_reset();
      start_run("fetch_to");
      bus.mem_ack = 1'b0;
      ok = 1;
      for (int c = 0; c <= TO; c++) begin
         if (state !== 3'd1 || bus.mem_req !== 1'b1) ok = 0;
         tick();
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL fetch_to wait: left FETCH early, state=%0d", state);
      end
      total++;
      if (state !== 3'd6 || outs() !== 10'b0000000001) begin
         bad++;
         $display("FAIL fetch_to fault: state=%0d outs=%b required state=6 outs=0000000001", state, outs());
      end
      ok = 1;
      for (int c = 0; c < 6; c++) begin
         run = c[0];
         bus.mem_ack = c[1];
         #1;
         if (state !== 3'd6 || outs() !== 10'b0000000001) ok = 0;
         tick();
      end
      bus.mem_ack = 1'b0;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL fault_sticky: state=%0d outs=%b required state=6 outs=0000000001", state, outs());
      end
`ifdef CORE_SEQUENCER_PERF_COUNTERS_EN
      total++;
      if (perf_cycles !== 32'(TO + 1) || perf_instret !== 32'd0) begin
         bad++;
         $display("FAIL perf_freeze: cycles=%0d instret=%0d required %0d 0", perf_cycles, perf_instret, TO + 1);
      end
`endif
      rst_n = 1'b0;
      #1;
      total++;
      if (state !== 3'd0 || fault !== 1'b0) begin
         bad++;
         $display("FAIL fault_clear: state=%0d fault=%0b required 0 0", state, fault);
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_mem_timeout();
      int nmem;
      do_reset();
      rd = 1; wr = 0; rf = 1;
      start_run("mem_to");
      nmem = 0;
      for (int c = 0; c < 30 && state != 3'd6; c++) begin
         bus.mem_ack = (state == 3'd1);
         if (state == 3'd4) nmem++;
         tick();
      end
      bus.mem_ack = 1'b0;
      total++;
      if (state !== 3'd6 || nmem != TO + 1 || bus.mem_req !== 1'b0 || fault !== 1'b1) begin
         bad++;
         $display("FAIL mem_to: state=%0d mem_cycles=%0d mem_req=%0b fault=%0b required 6 %0d 0 1",
                  state, nmem, bus.mem_req, fault, TO + 1);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      start_run("async_rst");
      bus.mem_ack = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.mem_req !== 1'b0 || state !== 3'd0) begin
         bad++;
         $display("FAIL async_rst: mem_req=%0b state=%0d required 0 0", bus.mem_req, state);
      end
      tick();
      rst_n = 1'b1;
      run = 1'b0;
   endtask

   task automatic test_random();
      int lat, sum_lat, nret;
      bit r_rd, r_wr, r_rf, r_br, r_tk, r_run;
      do_reset();
      sum_lat = 0;
      nret = 0;
      start_run("rand");
      for (int i = 0; i < 30; i++) begin
         r_rd  = ($urandom_range(0, 3) == 0);
         r_wr  = ($urandom_range(0, 3) == 0);
         r_rf  = $urandom_range(0, 1);
         r_br  = $urandom_range(0, 1);
         r_tk  = $urandom_range(0, 1);
         r_run = (i != 29) && ($urandom_range(0, 3) != 0);
         run_instr($sformatf("rand%0d", i), r_rd, r_wr, r_rf, r_br, r_tk,
                   $urandom_range(0, TO), $urandom_range(0, TO), r_run, lat);
         sum_lat += lat;
         nret++;
         if (!r_run && i != 29) begin
            repeat ($urandom_range(0, 3)) tick();
            start_run("rand_restart");
         end
      end
`ifdef CORE_SEQUENCER_PERF_COUNTERS_EN
      total++;
      if (perf_cycles !== 32'(sum_lat) || perf_instret !== 32'(nret)) begin
         bad++;
         $display("FAIL perf: cycles=%0d instret=%0d required %0d %0d", perf_cycles, perf_instret, sum_lat, nret);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_directed();
      test_fetch_timeout();
      test_mem_timeout();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
